// File: rtl/hn_data_pkg.sv
// Shared constants and helpers for the Hn ping-pong line buffer.
// Covers the error-flag bit positions, the read/write width ratio and odd-channel address mirroring.
package hn_data_pkg;

  localparam int ERR_OVERRUN  = 0;
  localparam int ERR_UNDERRUN = 1;
  localparam int ERR_ADDR     = 2;
  localparam int ERR_N        = 3;

  function automatic int calc_ratio(input int wr_w, input int rd_w);
    return wr_w / rd_w;
  endfunction

  function automatic int sel_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Reverses word order inside each SEG-long half of the frame.
  function automatic logic [31:0] mirror_addr(input logic [31:0] seg, input logic [31:0] addr);
    logic [31:0] res;
    if (addr < seg) begin
      res = seg - 32'd1 - addr;
    end else begin
      res = (32'd3 * seg) - 32'd1 - addr;
    end
    return res;
  endfunction

endpackage

// File: rtl/hn_bank_ram.sv
// Simple dual-port RAM holding both banks of one channel; the bank bit is the address MSB.
module hn_bank_ram #(
  parameter int AW = 11,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/hn_data_buf.sv
// Multi-channel ping-pong line buffer: wide frame writes, narrow serial reads,
// with optional address mirroring on odd channels for reverse-mounted chips.
module hn_data_buf
  import hn_data_pkg::*;
#(
  parameter int CH     = 4,
  parameter int WR_W   = 4,
  parameter int RD_W   = 1,
  parameter int SEG    = 400,
  parameter int WORDS  = 800,
  parameter int MIRROR = 1,
  parameter int WA_W   = 10,
  parameter int RA_W   = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [WA_W-1:0]      wr_addr,
  input  logic [CH*WR_W-1:0]   wr_data,
  input  logic                 wr_last,
  output logic                 wr_ready,
  input  logic                 rd_en,
  input  logic [RA_W-1:0]      rd_addr,
  input  logic                 rd_release,
  output logic                 frame_avail,
  output logic [CH*RD_W-1:0]   rd_data,
  output logic                 rd_valid,
  input  logic                 err_clr,
  output logic                 err_overrun,
  output logic                 err_underrun,
  output logic                 err_addr
);

  localparam int RATIO = calc_ratio(WR_W, RD_W);
  localparam int SL_W  = sel_width(RATIO);
  localparam logic [WA_W:0] WR_LIM = (WA_W+1)'(WORDS);
  localparam logic [RA_W:0] RD_LIM = (RA_W+1)'(WORDS * RATIO);

  logic             wptr_r, rptr_r;
  logic [1:0]       cnt_r, cnt_nxt_s;
  logic             wr_ready_r, frame_avail_r, rd_valid_r, data_ok_r;
  logic [SL_W-1:0]  slice_r;
  logic [ERR_N-1:0] err_r, err_new_s;
  logic             wr_ok_s, wr_in_s, commit_s, release_s, rd_ok_s, rd_in_s;
  logic [WA_W-1:0]  rd_word_s;
  logic [WR_W-1:0]  ram_q_s [CH];

  assign rd_word_s = WA_W'(rd_addr / RA_W'(RATIO));

  // Qualify strobes against frame state and range, and collect new error events.
  always_comb begin
    wr_ok_s   = wr_en & wr_ready_r;
    wr_in_s   = wr_ok_s & ({1'b0, wr_addr} < WR_LIM);
    commit_s  = wr_ok_s & wr_last;
    release_s = rd_release & frame_avail_r;
    rd_ok_s   = rd_en & frame_avail_r;
    rd_in_s   = rd_ok_s & ({1'b0, rd_addr} < RD_LIM);
    err_new_s = {ERR_N{1'b0}};
    err_new_s[ERR_OVERRUN]  = wr_en & ~wr_ready_r;
    err_new_s[ERR_UNDERRUN] = (rd_en | rd_release) & ~frame_avail_r;
    err_new_s[ERR_ADDR]     = (wr_ok_s & ~wr_in_s) | (rd_ok_s & ~rd_in_s);
  end

  // Outstanding-frame count; a simultaneous commit and release cancel out.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({commit_s, release_s})
      2'b10:   cnt_nxt_s = cnt_r + 2'd1;
      2'b01:   cnt_nxt_s = cnt_r - 2'd1;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Frame pointers, status outputs, read pipeline and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_r        <= 1'b0;
      rptr_r        <= 1'b0;
      cnt_r         <= 2'd0;
      wr_ready_r    <= 1'b1;
      frame_avail_r <= 1'b0;
      rd_valid_r    <= 1'b0;
      data_ok_r     <= 1'b0;
      slice_r       <= {SL_W{1'b0}};
      err_r         <= {ERR_N{1'b0}};
    end else begin
      if (commit_s) begin
        wptr_r <= ~wptr_r;
      end
      if (release_s) begin
        rptr_r <= ~rptr_r;
      end
      cnt_r         <= cnt_nxt_s;
      wr_ready_r    <= (cnt_nxt_s != 2'd2);
      frame_avail_r <= (cnt_nxt_s != 2'd0);
      rd_valid_r    <= rd_ok_s;
      // Out-of-range reads zero the output; underruns leave it untouched.
      if (rd_ok_s) begin
        data_ok_r <= rd_in_s;
        slice_r   <= SL_W'(rd_addr % RA_W'(RATIO));
      end
      err_r <= err_new_s | (err_r & ~{ERR_N{err_clr}});
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [WA_W-1:0] wa_s;
    if ((MIRROR != 0) && ((c % 2) == 1)) begin : g_mir
      assign wa_s = WA_W'(mirror_addr(32'(SEG), 32'(wr_addr)));
    end else begin : g_dir
      assign wa_s = wr_addr;
    end

    hn_bank_ram #(.AW(WA_W + 1), .DW(WR_W)) u_ram (
      .clk   (clk),
      .we    (wr_in_s & rstn),
      .waddr ({wptr_r, wa_s}),
      .wdata (wr_data[c*WR_W +: WR_W]),
      .re    (rd_in_s & rstn),
      .raddr ({rptr_r, rd_word_s}),
      .rdata (ram_q_s[c])
    );

    assign rd_data[c*RD_W +: RD_W] = data_ok_r ? ram_q_s[c][slice_r*RD_W +: RD_W] : {RD_W{1'b0}};
  end

  assign wr_ready     = wr_ready_r;
  assign frame_avail  = frame_avail_r;
  assign rd_valid     = rd_valid_r;
  assign err_overrun  = err_r[ERR_OVERRUN];
  assign err_underrun = err_r[ERR_UNDERRUN];
  assign err_addr     = err_r[ERR_ADDR];

endmodule

// File: tb/tb_hn_data_buf.sv
// Self-checking bench for hn_data_buf: frame-level reference model, a vector table
// for error/commit corners, directed frame sequences and a randomized phase.
module tb_hn_data_buf;

  localparam int CH = 4, WR_W = 4, RD_W = 1, SEG = 400, WORDS = 800, WA_W = 10, RA_W = 12;
  localparam int RATIO = WR_W / RD_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstn, wr_en, wr_last, rd_en, rd_release, err_clr;
  logic [WA_W-1:0]     wr_addr;
  logic [CH*WR_W-1:0]  wr_data;
  logic [RA_W-1:0]     rd_addr;
  logic                wr_ready, frame_avail, rd_valid, err_overrun, err_underrun, err_addr;
  logic [CH*RD_W-1:0]  rd_data;

  hn_data_buf #(.CH(CH), .WR_W(WR_W), .RD_W(RD_W), .SEG(SEG), .WORDS(WORDS), .MIRROR(1),
                .WA_W(WA_W), .RA_W(RA_W)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_release(rd_release), .frame_avail(frame_avail), .rd_data(rd_data),
    .rd_valid(rd_valid), .err_clr(err_clr), .err_overrun(err_overrun),
    .err_underrun(err_underrun), .err_addr(err_addr)
  );

  // Reference model: two banks of logical storage plus frame bookkeeping.
  logic [WR_W-1:0]    mem [2][CH][WORDS];
  int                 m_w, m_r, m_cnt;
  logic [CH*RD_W-1:0] e_data;
  logic               e_valid;
  logic [2:0]         e_err;   // {addr, underrun, overrun}
  int                 checks = 0;
  int                 errors = 0;

  typedef struct {
    logic rd_en, rd_release, wr_en, wr_last, err_clr;
    int   wr_addr, rd_addr;
    logic e_valid, e_avail, e_ready;
    logic [2:0] e_err;
  } vec_t;
  vec_t vt[8];

  function automatic int phys(input int c, input int a);
    if (c % 2 == 1) return (a < SEG) ? SEG - 1 - a : 3 * SEG - 1 - a;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rstn = 1'b1; wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_release = 1'b0; err_clr = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  // Advance one clock: update the model from the driven inputs, then compare every output.
  task automatic tick();
    logic wr_rdy, avail;
    logic [2:0] ne;
    if (!rstn) begin
      m_w = 0; m_r = 0; m_cnt = 0; e_data = '0; e_valid = 1'b0; e_err = 3'b000;
    end else begin
      wr_rdy = (m_cnt != 2); avail = (m_cnt != 0); ne = 3'b000;
      if (wr_en && !wr_rdy) ne[0] = 1'b1;
      if ((rd_en || rd_release) && !avail) ne[1] = 1'b1;
      e_valid = 1'b0;
      if (rd_en && avail) begin
        e_valid = 1'b1;
        if (int'(rd_addr) < WORDS * RATIO) begin
          for (int c = 0; c < CH; c++)
            e_data[c] = mem[m_r][c][int'(rd_addr) / RATIO][int'(rd_addr) % RATIO];
        end else begin
          e_data = '0; ne[2] = 1'b1;
        end
      end
      if (wr_en && wr_rdy) begin
        if (int'(wr_addr) < WORDS) begin
          for (int c = 0; c < CH; c++) mem[m_w][c][phys(c, int'(wr_addr))] = wr_data[c*WR_W +: WR_W];
        end else begin
          ne[2] = 1'b1;
        end
        if (wr_last) begin m_w ^= 1; m_cnt++; end
      end
      if (rd_release && avail) begin m_r ^= 1; m_cnt--; end
      e_err = ne | (err_clr ? 3'b000 : e_err);
    end
    @(posedge clk); #1;
    check("rd_valid", rd_valid, e_valid);
    check("rd_data", rd_data, e_data);
    check("wr_ready", wr_ready, m_cnt != 2);
    check("frame_avail", frame_avail, m_cnt != 0);
    check("err_overrun", err_overrun, e_err[0]);
    check("err_underrun", err_underrun, e_err[1]);
    check("err_addr", err_addr, e_err[2]);
  endtask

  task automatic wr(input int a, input logic [CH*WR_W-1:0] d, input logic last, input logic rel);
    idle(); wr_en = 1'b1; wr_addr = WA_W'(a); wr_data = d; wr_last = last; rd_release = rel; tick();
  endtask

  task automatic rd(input int a);
    idle(); rd_en = 1'b1; rd_addr = RA_W'(a); tick();
  endtask

  task automatic rel();
    idle(); rd_release = 1'b1; tick();
  endtask

  // mode 0: random data, 1: ch0 = address nibble, 2: mirror pattern at words 0 and 400.
  task automatic write_frame(input int mode, input logic rel_on_last);
    logic [CH*WR_W-1:0] d;
    logic [WA_W-1:0] av;
    for (int a = 0; a < WORDS; a++) begin
      d = $urandom();
      av = WA_W'(a);
      if (mode == 1) d[3:0] = av[3:0];
      if (mode == 2 && a == 0)   d = {CH{4'hA}};
      if (mode == 2 && a == 400) d = {CH{4'h5}};
      wr(a, d, a == WORDS - 1, rel_on_last && (a == WORDS - 1));
    end
  endtask

  task automatic read_word(input int w, output logic [CH*WR_W-1:0] word);
    word = '0;
    for (int k = 0; k < RATIO; k++) begin
      rd(w * RATIO + k);
      for (int c = 0; c < CH; c++) word[c*WR_W + k] = rd_data[c];
    end
  endtask

  initial begin
    logic [CH*WR_W-1:0] word;
    int exp_bit;

    //                rd  rel wr  last clr  waddr raddr  valid avail ready err
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,   0,    1'b0, 1'b0, 1'b1, 3'b010};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 800, 0,    1'b0, 1'b0, 1'b1, 3'b110};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0,    1'b0, 1'b0, 1'b1, 3'b000};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 800, 0,    1'b0, 1'b1, 1'b1, 3'b100};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0,   4000, 1'b1, 1'b1, 1'b1, 3'b100};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0,    1'b0, 1'b1, 1'b1, 3'b000};
    vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,   0,    1'b0, 1'b0, 1'b1, 3'b000};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,   0,    1'b0, 1'b0, 1'b1, 3'b010};

    for (int b = 0; b < 2; b++)
      for (int c = 0; c < CH; c++)
        for (int w = 0; w < WORDS; w++) mem[b][c][w] = '0;

    idle(); rstn = 1'b0; tick(); tick();
    check("reset_ready", wr_ready, 1'b1);
    check("reset_avail", frame_avail, 1'b0);
    check("reset_rd_data", rd_data, 4'h0);

    // Error and commit corners.
    for (int i = 0; i < 8; i++) begin
      idle();
      rd_en = vt[i].rd_en; rd_release = vt[i].rd_release; wr_en = vt[i].wr_en;
      wr_last = vt[i].wr_last; err_clr = vt[i].err_clr;
      wr_addr = WA_W'(vt[i].wr_addr); rd_addr = RA_W'(vt[i].rd_addr); wr_data = $urandom();
      tick();
      check("tbl_valid", rd_valid, vt[i].e_valid);
      check("tbl_avail", frame_avail, vt[i].e_avail);
      check("tbl_ready", wr_ready, vt[i].e_ready);
      check("tbl_err", {err_addr, err_underrun, err_overrun}, vt[i].e_err);
      if (vt[i].e_valid) check("tbl_zero_data", rd_data, 4'h0);
    end

    // Single frame, full sequential read.
    write_frame(1, 1'b0);
    check("single_avail", frame_avail, 1'b1);
    for (int a = 0; a < WORDS * RATIO; a++) begin
      rd(a);
      exp_bit = ((a / 4) >> (a % 4)) & 1;
      check("single_ch0", rd_data[0], exp_bit[0]);
    end
    rel();

    // Mirroring on odd channels.
    write_frame(2, 1'b0);
    read_word(399, word); check("mirror_ch1_w399", word[7:4], 4'hA);
    read_word(799, word); check("mirror_ch1_w799", word[7:4], 4'h5);
    read_word(0, word);   check("mirror_ch0_w0", word[3:0], 4'hA);
    read_word(400, word); check("mirror_ch0_w400", word[3:0], 4'h5);
    rel();

    // Ping-pong: two outstanding frames, then an overrun attempt.
    write_frame(0, 1'b0);
    write_frame(0, 1'b0);
    check("pp_ready_low", wr_ready, 1'b0);
    wr(5, $urandom(), 1'b1, 1'b0);
    check("pp_overrun", err_overrun, 1'b1);
    for (int i = 0; i < 100; i++) rd($urandom_range(0, WORDS * RATIO - 1));
    rel();
    check("pp_ready_back", wr_ready, 1'b1);
    for (int i = 0; i < 200; i++) rd($urandom_range(0, WORDS * RATIO - 1));

    // Commit and release together with one frame outstanding.
    write_frame(0, 1'b1);
    check("swap_avail", frame_avail, 1'b1);
    check("swap_ready", wr_ready, 1'b1);
    for (int i = 0; i < 200; i++) rd($urandom_range(0, WORDS * RATIO - 1));

    // Reset in the middle of a read stream.
    rd(10); rd(11);
    idle(); rd_en = 1'b1; rd_addr = 12'd12; rstn = 1'b0; tick();
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 4'h0);
    check("rst_avail", frame_avail, 1'b0);
    check("rst_ready", wr_ready, 1'b1);

    // Randomized mix of all operations.
    for (int i = 0; i < 4000; i++) begin
      idle();
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = WA_W'($urandom_range(0, 820));
      wr_data = $urandom();
      wr_last = ($urandom_range(0, 63) == 0);
      rd_en = 1'($urandom_range(0, 1));
      rd_addr = RA_W'($urandom_range(0, 3250));
      rd_release = ($urandom_range(0, 40) == 0);
      err_clr = ($urandom_range(0, 30) == 0);
      rstn = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
